// File: rtl/bg_line_fetcher.sv
// bg_line_fetcher
//   Background line fetcher sitting in front of the VGA pixel stage.
//   While line N is on screen, the 32 tiles of line N+1 are fetched
//   (nametable, then pattern ROM) into the hidden half of a ping-pong
//   line buffer. The visible half is read one pixel per cycle and turned
//   into a 4-bit colour code {palette, index}. Vertical scroll is latched
//   once per frame and wraps at the game-window height.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   frame_start        one-cycle pulse at vsync; latches scroll_y, clears overrun
//   line_start         one-cycle pulse per game line; swaps buffers, starts fetch
//   next_line_y        game-window line to fetch (0..GAME_LINES-1)
//   scroll_y           vertical scroll, sampled on frame_start
//   nt_rd_en/nt_addr   nametable read port, nt_data valid one cycle later
//   pat_rd_en/pat_addr pattern ROM read port, pat_data valid one cycle later
//   pix_valid_in/pix_x pixel request from the VGA timing
//   pix_color/pix_valid colour code and qualifier, one cycle after the request
//   fetch_busy         a line fetch is in progress
//   fetch_overrun      sticky: a line_start arrived while a fetch was running

module bg_line_fetcher #(
  parameter int GAME_LINES     = 240,
  parameter int TILES_PER_LINE = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic [7:0]  next_line_y,
  input  logic [7:0]  scroll_y,
  output logic        nt_rd_en,
  output logic [9:0]  nt_addr,
  input  logic [9:0]  nt_data,
  output logic        pat_rd_en,
  output logic [10:0] pat_addr,
  input  logic [15:0] pat_data,
  input  logic        pix_valid_in,
  input  logic [7:0]  pix_x,
  output logic [3:0]  pix_color,
  output logic        pix_valid,
  output logic        fetch_busy,
  output logic        fetch_overrun
);

  localparam logic [4:0] LAST_COL = 5'(TILES_PER_LINE - 1);
  localparam logic [8:0] LINES_9  = 9'(GAME_LINES);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [4:0]  col_q, col_d;
  logic [4:0]  tile_row_q, tile_row_d;
  logic [2:0]  fine_y_q, fine_y_d;
  logic [7:0]  scroll_lat_q, scroll_lat_d;
  logic        disp_q, disp_d;
  logic        overrun_q, overrun_d;
  logic        nt_pend_q, nt_pend_d;
  logic [4:0]  nt_col_q, nt_col_d;
  logic        pat_pend_q, pat_pend_d;
  logic [4:0]  pat_col_q, pat_col_d;
  logic [1:0]  pat_pal_q, pat_pal_d;
  logic        pix_valid_q, pix_valid_d;
  logic [3:0]  pix_color_q, pix_color_d;

  // Line buffer: [buffer][column] = {palette[1:0], plane1[7:0], plane0[7:0]}
  logic [17:0] line_buf [2][TILES_PER_LINE];

  logic        busy;
  logic        wr_en;
  logic [7:0]  scroll_new;
  logic [7:0]  scroll_use;
  logic [8:0]  row_sum;
  logic [7:0]  eff_y;
  logic [17:0] rd_entry;
  logic [7:0]  rd_plane0;
  logic [7:0]  rd_plane1;
  logic [2:0]  bit_sel;

  assign busy = (state_q != IDLE);

  // State register; async reset lands in IDLE so strobes drop at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A line_start in any state restarts the fetch;
  // DRAIN reuses the column counter (wrapped to 0) to count its 2 cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (line_start) state_d = ISSUE;
      ISSUE: begin
        if (line_start)            state_d = ISSUE;
        else if (col_q == LAST_COL) state_d = DRAIN;
      end
      DRAIN: begin
        if (line_start)        state_d = ISSUE;
        else if (col_q == 5'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. pat_addr comes straight from nt_data so the pattern read
  // follows the nametable read by exactly one cycle.
  always_comb begin
    nt_rd_en      = (state_q == ISSUE);
    nt_addr       = '0;
    pat_rd_en     = nt_pend_q;
    pat_addr      = '0;
    fetch_busy    = busy;
    fetch_overrun = overrun_q;
    pix_color     = pix_color_q;
    pix_valid     = pix_valid_q;
    if (state_q == ISSUE) nt_addr  = {tile_row_q, col_q};
    if (nt_pend_q)        pat_addr = {nt_data[7:0], fine_y_q};
  end

  // Scroll clamp and wrapped row arithmetic. A frame_start in the same
  // cycle as line_start already applies to that line.
  always_comb begin
    scroll_new = ({1'b0, scroll_y} >= LINES_9) ? 8'd0 : scroll_y;
    scroll_use = frame_start ? scroll_new : scroll_lat_q;
    row_sum    = {1'b0, next_line_y} + {1'b0, scroll_use};
    eff_y      = (row_sum >= LINES_9) ? 8'(row_sum - LINES_9) : row_sum[7:0];
  end

  // Datapath next-state: fetch pipeline, buffer select, overrun flag and
  // pixel read. line_start cancels any read still in flight.
  always_comb begin
    scroll_lat_d = frame_start ? scroll_new : scroll_lat_q;
    disp_d       = line_start ? ~disp_q : disp_q;
    tile_row_d   = line_start ? eff_y[7:3] : tile_row_q;
    fine_y_d     = line_start ? eff_y[2:0] : fine_y_q;

    overrun_d = overrun_q;
    if (line_start && busy) overrun_d = 1'b1;
    else if (frame_start)   overrun_d = 1'b0;

    col_d = 5'd0;
    if (!line_start && busy) col_d = col_q + 5'd1;

    nt_pend_d  = (state_q == ISSUE) && !line_start;
    nt_col_d   = col_q;
    pat_pend_d = nt_pend_q && !line_start;
    pat_col_d  = nt_col_q;
    pat_pal_d  = nt_data[9:8];
    wr_en      = pat_pend_q && !line_start;

    rd_entry    = line_buf[disp_q][pix_x[7:3]];
    rd_plane1   = rd_entry[15:8];
    rd_plane0   = rd_entry[7:0];
    bit_sel     = 3'd7 - pix_x[2:0];
    pix_valid_d = pix_valid_in;
    pix_color_d = pix_valid_in ?
                  {rd_entry[17:16], rd_plane1[bit_sel], rd_plane0[bit_sel]} : 4'd0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q        <= '0;
      tile_row_q   <= '0;
      fine_y_q     <= '0;
      scroll_lat_q <= '0;
      disp_q       <= 1'b0;
      overrun_q    <= 1'b0;
      nt_pend_q    <= 1'b0;
      nt_col_q     <= '0;
      pat_pend_q   <= 1'b0;
      pat_col_q    <= '0;
      pat_pal_q    <= '0;
      pix_valid_q  <= 1'b0;
      pix_color_q  <= '0;
    end else begin
      col_q        <= col_d;
      tile_row_q   <= tile_row_d;
      fine_y_q     <= fine_y_d;
      scroll_lat_q <= scroll_lat_d;
      disp_q       <= disp_d;
      overrun_q    <= overrun_d;
      nt_pend_q    <= nt_pend_d;
      nt_col_q     <= nt_col_d;
      pat_pend_q   <= pat_pend_d;
      pat_col_q    <= pat_col_d;
      pat_pal_q    <= pat_pal_d;
      pix_valid_q  <= pix_valid_d;
      pix_color_q  <= pix_color_d;
    end
  end

  // Buffer storage has no reset; writes always go to the hidden half.
  always_ff @(posedge clk) begin
    if (wr_en) line_buf[~disp_q][pat_col_q] <= {pat_pal_q, pat_data};
  end

endmodule

// File: tb/tb_bg_line_fetcher.sv
// Testbench for bg_line_fetcher: random nametable/pattern ROM contents,
// a line model built from the ROM arrays, and per-feature test tasks.

module tb_bg_line_fetcher;

  logic        clk = 1'b0;
  logic        rstn;
  logic        frame_start, line_start;
  logic [7:0]  next_line_y, scroll_y;
  logic        nt_rd_en;
  logic [9:0]  nt_addr;
  logic [9:0]  nt_data;
  logic        pat_rd_en;
  logic [10:0] pat_addr;
  logic [15:0] pat_data;
  logic        pix_valid_in;
  logic [7:0]  pix_x;
  logic [3:0]  pix_color;
  logic        pix_valid, fetch_busy, fetch_overrun;

  int checks   = 0;
  int failures = 0;

  logic [9:0]  nt_mem  [1024];
  logic [15:0] pat_mem [2048];
  logic [17:0] exp_line [32];

  bg_line_fetcher #(.GAME_LINES(240), .TILES_PER_LINE(32)) dut (
    .clk(clk), .rstn(rstn), .frame_start(frame_start), .line_start(line_start),
    .next_line_y(next_line_y), .scroll_y(scroll_y),
    .nt_rd_en(nt_rd_en), .nt_addr(nt_addr), .nt_data(nt_data),
    .pat_rd_en(pat_rd_en), .pat_addr(pat_addr), .pat_data(pat_data),
    .pix_valid_in(pix_valid_in), .pix_x(pix_x), .pix_color(pix_color),
    .pix_valid(pix_valid), .fetch_busy(fetch_busy), .fetch_overrun(fetch_overrun)
  );

  always #5 clk = ~clk;

  // Synchronous ROMs: data one cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    nt_data  <= nt_rd_en  ? nt_mem[nt_addr]   : 10'($urandom);
    pat_data <= pat_rd_en ? pat_mem[pat_addr] : 16'($urandom);
  end

  // Reference model: effective line after clamped scroll and wrap.
  function automatic int eff_line(int y, int s);
    int s2;
    s2 = (s >= 240) ? 0 : s;
    return (y + s2) % 240;
  endfunction

  // Reference model: the 32 buffer entries a complete fetch of line eff holds.
  task automatic build_line(input int eff);
    logic [9:0] nt;
    for (int c = 0; c < 32; c++) begin
      nt = nt_mem[(eff / 8) * 32 + c];
      exp_line[c] = {nt[9:8], pat_mem[int'(nt[7:0]) * 8 + eff % 8]};
    end
  endtask

  function automatic logic [3:0] exp_color(int x);
    logic [17:0] e;
    int b;
    e = exp_line[x / 8];
    b = 7 - x % 8;
    return {e[17:16], e[8 + b], e[b]};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_frame(input int s);
    frame_start = 1'b1;
    scroll_y    = 8'(s);
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic pulse_line(input int y);
    line_start  = 1'b1;
    next_line_y = 8'(y);
    @(negedge clk);
    line_start  = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    pix_valid_in = 1'b1;
    idle(3);
    checks++; if (nt_rd_en !== 1'b0)       begin failures++; $display("[TB] FAIL reset_nt_rd_en got %b exp 0", nt_rd_en); end
    checks++; if (pat_rd_en !== 1'b0)      begin failures++; $display("[TB] FAIL reset_pat_rd_en got %b exp 0", pat_rd_en); end
    checks++; if (nt_addr !== 10'd0)       begin failures++; $display("[TB] FAIL reset_nt_addr got %h exp 0", nt_addr); end
    checks++; if (pat_addr !== 11'd0)      begin failures++; $display("[TB] FAIL reset_pat_addr got %h exp 0", pat_addr); end
    checks++; if (pix_color !== 4'd0)      begin failures++; $display("[TB] FAIL reset_pix_color got %h exp 0", pix_color); end
    checks++; if (pix_valid !== 1'b0)      begin failures++; $display("[TB] FAIL reset_pix_valid got %b exp 0", pix_valid); end
    checks++; if (fetch_busy !== 1'b0)     begin failures++; $display("[TB] FAIL reset_busy got %b exp 0", fetch_busy); end
    checks++; if (fetch_overrun !== 1'b0)  begin failures++; $display("[TB] FAIL reset_overrun got %b exp 0", fetch_overrun); end
    pix_valid_in = 1'b0;
    rstn = 1'b1;
    idle(2);
  endtask

  // Line 0, no scroll: full strobe/address timeline, then pixel readback.
  task automatic test_basic_fetch;
    logic       eb, en, ep;
    logic [9:0] ena;
    logic [10:0] epa;
    nt_mem[5]   = 10'h205;
    pat_mem[40] = 16'h0080;
    pulse_frame(0);
    idle(2);
    pulse_line(0);
    for (int k = 1; k <= 36; k++) begin
      eb  = (k <= 34);
      en  = (k <= 32);
      ena = en ? 10'(k - 1) : 10'd0;
      ep  = (k >= 2) && (k <= 33);
      epa = 11'd0;
      if (ep) epa = {nt_mem[k - 2][7:0], 3'd0};
      checks++; if (fetch_busy !== eb)  begin failures++; $display("[TB] FAIL fetch_busy cyc %0d got %b exp %b", k, fetch_busy, eb); end
      checks++; if (nt_rd_en !== en)    begin failures++; $display("[TB] FAIL nt_rd_en cyc %0d got %b exp %b", k, nt_rd_en, en); end
      checks++; if (nt_addr !== ena)    begin failures++; $display("[TB] FAIL nt_addr cyc %0d got %h exp %h", k, nt_addr, ena); end
      checks++; if (pat_rd_en !== ep)   begin failures++; $display("[TB] FAIL pat_rd_en cyc %0d got %b exp %b", k, pat_rd_en, ep); end
      checks++; if (pat_addr !== epa)   begin failures++; $display("[TB] FAIL pat_addr cyc %0d got %h exp %h", k, pat_addr, epa); end
      checks++; if (fetch_overrun !== 1'b0) begin failures++; $display("[TB] FAIL overrun_basic cyc %0d got %b exp 0", k, fetch_overrun); end
      @(negedge clk);
    end
    build_line(0);
    pulse_line(1);
    pix_x = 8'd40; pix_valid_in = 1'b1;
    @(negedge clk);
    checks++; if (pix_color !== 4'b1001) begin failures++; $display("[TB] FAIL pix_x40 got %b exp 1001", pix_color); end
    pix_x = 8'd41;
    @(negedge clk);
    checks++; if (pix_color !== 4'b1000) begin failures++; $display("[TB] FAIL pix_x41 got %b exp 1000", pix_color); end
    for (int i = 0; i < 20; i++) begin
      int x;
      logic v;
      x = (i == 0) ? 0 : (i == 1) ? 255 : int'($urandom_range(255));
      v = (i < 2) ? 1'b1 : ($urandom_range(3) != 0);
      pix_x = 8'(x); pix_valid_in = v;
      @(negedge clk);
      checks++; if (pix_valid !== v) begin failures++; $display("[TB] FAIL pix_valid x=%0d got %b exp %b", x, pix_valid, v); end
      checks++; if (pix_color !== (v ? exp_color(x) : 4'd0)) begin failures++; $display("[TB] FAIL pix_color line0 x=%0d got %h exp %h", x, pix_color, (v ? exp_color(x) : 4'd0)); end
    end
    pix_valid_in = 1'b0;
    idle(40);
  endtask

  // Scroll 20 with line 230 wraps to effective line 10.
  task automatic test_scroll_wrap;
    pulse_frame(20);
    idle(1);
    pulse_line(230);
    checks++; if (nt_addr !== 10'd32) begin failures++; $display("[TB] FAIL wrap_nt_addr got %0d exp 32", nt_addr); end
    @(negedge clk);
    checks++; if (pat_addr !== {nt_mem[32][7:0], 3'd2}) begin failures++; $display("[TB] FAIL wrap_pat_addr got %h exp %h", pat_addr, {nt_mem[32][7:0], 3'd2}); end
    idle(40);
    build_line(eff_line(230, 20));
    pulse_line(0);
    for (int i = 0; i < 16; i++) begin
      int x;
      x = int'($urandom_range(255));
      pix_x = 8'(x); pix_valid_in = 1'b1;
      @(negedge clk);
      checks++; if (pix_color !== exp_color(x)) begin failures++; $display("[TB] FAIL pix_color wrap x=%0d got %h exp %h", x, pix_color, exp_color(x)); end
    end
    pix_valid_in = 1'b0;
    idle(40);
  endtask

  // Out-of-range scroll is treated as 0.
  task automatic test_scroll_clamp;
    pulse_frame(250);
    idle(1);
    pulse_line(17);
    checks++; if (nt_addr !== 10'd64) begin failures++; $display("[TB] FAIL clamp_nt_addr got %0d exp 64", nt_addr); end
    @(negedge clk);
    checks++; if (pat_addr !== {nt_mem[64][7:0], 3'd1}) begin failures++; $display("[TB] FAIL clamp_pat_addr got %h exp %h", pat_addr, {nt_mem[64][7:0], 3'd1}); end
    idle(40);
  endtask

  // frame_start coincident with line_start: the new scroll applies.
  task automatic test_frame_line_same_cycle;
    frame_start = 1'b1; scroll_y = 8'd8;
    line_start  = 1'b1; next_line_y = 8'd0;
    @(negedge clk);
    frame_start = 1'b0; line_start = 1'b0;
    checks++; if (nt_addr !== 10'd32) begin failures++; $display("[TB] FAIL same_cycle_nt_addr got %0d exp 32", nt_addr); end
    idle(40);
  endtask

  // Random scroll/line pairs with the next line_start exactly one cycle
  // after the busy window closes: no overrun, full line displayed.
  task automatic test_back_to_back;
    for (int n = 0; n < 6; n++) begin
      int s, y, e;
      s = int'($urandom_range(255));
      y = int'($urandom_range(239));
      e = eff_line(y, s);
      pulse_frame(s);
      pulse_line(y);
      checks++; if (nt_addr !== 10'((e / 8) * 32)) begin failures++; $display("[TB] FAIL rand_nt_addr s=%0d y=%0d got %0d exp %0d", s, y, nt_addr, (e / 8) * 32); end
      @(negedge clk);
      checks++; if (pat_addr !== {nt_mem[(e / 8) * 32][7:0], 3'(e % 8)}) begin failures++; $display("[TB] FAIL rand_pat_addr s=%0d y=%0d got %h", s, y, pat_addr); end
      idle(32);
      checks++; if (fetch_busy !== 1'b1) begin failures++; $display("[TB] FAIL busy_cycle34 got %b exp 1", fetch_busy); end
      @(negedge clk);
      checks++; if (fetch_busy !== 1'b0) begin failures++; $display("[TB] FAIL busy_cycle35 got %b exp 0", fetch_busy); end
      build_line(e);
      pulse_line(int'($urandom_range(239)));
      checks++; if (fetch_overrun !== 1'b0) begin failures++; $display("[TB] FAIL b2b_overrun got %b exp 0", fetch_overrun); end
      for (int i = 0; i < 12; i++) begin
        int x;
        x = (i == 0) ? 0 : (i == 1) ? 255 : int'($urandom_range(255));
        pix_x = 8'(x); pix_valid_in = 1'b1;
        @(negedge clk);
        checks++; if (pix_color !== exp_color(x)) begin failures++; $display("[TB] FAIL pix_color b2b x=%0d got %h exp %h", x, pix_color, exp_color(x)); end
      end
      pix_valid_in = 1'b0;
      idle(40);
    end
  endtask

  // line_start 10 cycles into a fetch: overrun, restart at col 0, pending
  // reads dropped; frame_start clears the flag.
  task automatic test_overrun;
    pulse_frame(0);
    pulse_line(8);
    idle(9);
    pulse_line(16);
    checks++; if (fetch_overrun !== 1'b1) begin failures++; $display("[TB] FAIL overrun_set got %b exp 1", fetch_overrun); end
    checks++; if (nt_addr !== 10'd64)     begin failures++; $display("[TB] FAIL overrun_restart_addr got %0d exp 64", nt_addr); end
    checks++; if (pat_rd_en !== 1'b0)     begin failures++; $display("[TB] FAIL overrun_drop_pat got %b exp 0", pat_rd_en); end
    idle(33);
    checks++; if (fetch_busy !== 1'b1)    begin failures++; $display("[TB] FAIL overrun_busy34 got %b exp 1", fetch_busy); end
    @(negedge clk);
    checks++; if (fetch_busy !== 1'b0)    begin failures++; $display("[TB] FAIL overrun_busy35 got %b exp 0", fetch_busy); end
    checks++; if (fetch_overrun !== 1'b1) begin failures++; $display("[TB] FAIL overrun_sticky got %b exp 1", fetch_overrun); end
    pulse_frame(0);
    checks++; if (fetch_overrun !== 1'b0) begin failures++; $display("[TB] FAIL overrun_clear got %b exp 0", fetch_overrun); end
    idle(2);
  endtask

  // Async reset in the middle of ISSUE.
  task automatic test_reset_mid_fetch;
    int strobes;
    pulse_frame(16);
    pix_x = 8'd0; pix_valid_in = 1'b1;
    pulse_line(0);
    idle(5);
    checks++; if (nt_addr !== 10'd69) begin failures++; $display("[TB] FAIL pre_reset_nt_addr got %0d exp 69", nt_addr); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (nt_rd_en !== 1'b0)   begin failures++; $display("[TB] FAIL rst_mid_nt_rd_en got %b exp 0", nt_rd_en); end
    checks++; if (pat_rd_en !== 1'b0)  begin failures++; $display("[TB] FAIL rst_mid_pat_rd_en got %b exp 0", pat_rd_en); end
    checks++; if (fetch_busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_busy got %b exp 0", fetch_busy); end
    checks++; if (pix_valid !== 1'b0)  begin failures++; $display("[TB] FAIL rst_mid_pix_valid got %b exp 0", pix_valid); end
    pix_valid_in = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    strobes = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (nt_rd_en || pat_rd_en) strobes++;
    end
    checks++; if (strobes !== 0) begin failures++; $display("[TB] FAIL post_reset_strobes got %0d exp 0", strobes); end
    pulse_line(0);
    checks++; if (nt_rd_en !== 1'b1 || nt_addr !== 10'd0) begin failures++; $display("[TB] FAIL post_reset_fetch got en=%b addr=%0d exp en=1 addr=0", nt_rd_en, nt_addr); end
    idle(40);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstn = 1'b0;
    frame_start = 1'b0; line_start = 1'b0;
    next_line_y = 8'd0; scroll_y = 8'd0;
    pix_valid_in = 1'b0; pix_x = 8'd0;
    for (int i = 0; i < 1024; i++) nt_mem[i]  = 10'($urandom);
    for (int i = 0; i < 2048; i++) pat_mem[i] = 16'($urandom);
    @(negedge clk);
    test_reset;
    test_basic_fetch;
    test_scroll_wrap;
    test_scroll_clamp;
    test_frame_line_same_cycle;
    test_back_to_back;
    test_overrun;
    test_reset_mid_fetch;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bg_line_fetcher.md
Name: bg_line_fetcher

Overview:
- Upstream of the VGA driver pixel stage; feeds background pixels into the game window.
- During display of line N, fetches the 32 background tiles of line N+1 (nametable + pattern ROM) into a ping-pong line buffer.
- Serves 4-bit colour codes {palette, index} for the current line on demand from the VGA pixel position.
- Supports vertical scroll, latched once per frame, with wrap at the game-window height.

Parameters:
- GAME_LINES, 240, visible game-window lines; vertical wrap modulus.
- TILES_PER_LINE, 32, tiles per line (256 px / 8).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse, start of frame (vsync)
- line_start  in  1  one-cycle pulse, start of each game line
- next_line_y  in  8  game-window line (0..239) to fetch on line_start
- scroll_y  in  8  vertical scroll, sampled on frame_start
- nt_rd_en  out  1  nametable read strobe
- nt_addr  out  10  nametable address {tile_row[4:0], col[4:0]}
- nt_data  in  10  {palette[1:0], tile_id[7:0]}; valid 1 cycle after nt_rd_en
- pat_rd_en  out  1  pattern ROM read strobe
- pat_addr  out  11  {tile_id[7:0], fine_y[2:0]}
- pat_data  in  16  [15:8] plane1, [7:0] plane0; bit 7 = leftmost px; valid 1 cycle after pat_rd_en
- pix_valid_in  in  1  VGA position inside game window
- pix_x  in  8  game-window x, 0..255
- pix_color  out  4  {palette[1:0], index[1:0]}
- pix_valid  out  1  pix_valid_in delayed 1 cycle
- fetch_busy  out  1  fetch in progress
- fetch_overrun  out  1  sticky: line_start arrived during fetch

Behaviour:
- Reset values:
  - Outputs: pix_color=0, pix_valid=0, nt_rd_en=0, pat_rd_en=0, nt_addr=0, pat_addr=0, fetch_busy=0, fetch_overrun=0.
  - Internal: scroll latch=0, display buffer select=0, FSM=IDLE.
  - Line buffer contents are undefined after reset.
- Scroll latch:
  - On frame_start: scroll_lat <= (scroll_y>=GAME_LINES) ? 0 : scroll_y.
  - frame_start also clears fetch_overrun.
- Row math, computed in 9 bits, from next_line_y sampled at line_start:
  - sum = next_line_y + scroll_lat; eff_y = (sum>=GAME_LINES) ? sum-GAME_LINES : sum.
  - tile_row = eff_y[7:3]; fine_y = eff_y[2:0].
- On line_start:
  - Toggle display select.
  - Start a fetch into the non-display buffer.
  - If frame_start is in the same cycle, the new scroll_lat is used.
- FSM, IDLE -> ISSUE -> DRAIN -> IDLE:
  - IDLE: fetch_busy=0. line_start -> ISSUE, col=0.
  - ISSUE (32 cycles): nt_rd_en=1, nt_addr={tile_row,col}, col++.
    - One cycle after each nt read: latch nt_data palette; pat_rd_en=1, pat_addr={tile_id,fine_y}.
    - One cycle after each pat read: write {palette, pat_data} (18 b) to fetch_buf[col].
    - Pipelined, one tile per cycle.
  - After col=31 is issued -> DRAIN (2 cycles) to complete the last pat read and write -> IDLE.
  - Fetch time: 34 cycles from line_start to the last buffer write. fetch_busy is high for exactly those 34 cycles, starting the cycle after line_start.
- Overrun: line_start while fetch_busy=1:
  - Set fetch_overrun.
  - Abort the in-flight fetch; drop pending reads.
  - Swap buffers and restart at col=0 with the new row.
  - The display buffer then holds a partially written line (acceptable).
- Pixel read, 1-cycle latency:
  - e = disp_buf[pix_x[7:3]]; b = 7-pix_x[2:0].
  - Next cycle: pix_color = {e.palette, e.plane1[b], e.plane0[b]}; pix_valid = pix_valid_in.
  - pix_color=0 when pix_valid_in was 0.
- Buffer write and read never collide: they always target opposite buffers.
- nt_data/pat_data are ignored when no read was issued in the previous cycle.
- Asynchronous reset mid-fetch forces IDLE immediately. No ROM read strobes are issued after reset until the next line_start.

Test Plan:
- Reset, then line_start with next_line_y=0, scroll_y=0 -> nt_addr 0..31 on consecutive cycles, pat_addr={tile_id,3'd0}; fetch_busy high 34 cycles; fetch_overrun=0.
- Fill tile 5 (nt=10'h2_05), pattern plane0=8'h80, plane1=8'h00 at fine_y=0. Next line_start swaps buffers; pix_x=40 -> pix_color=4'b1001 one cycle later; pix_x=41 -> 4'b1000.
- frame_start with scroll_y=20, line_start with next_line_y=230 -> eff_y=10: tile_row=1, fine_y=2, first nt_addr=10'd32.
- scroll_y=250 at frame_start -> treated as 0; next_line_y=17 gives tile_row=2, fine_y=1.
- line_start again 10 cycles after a fetch starts -> fetch_overrun=1, nt_addr restarts at col 0. Next frame_start -> fetch_overrun=0.
- Assert rstn low mid-ISSUE -> nt_rd_en/pat_rd_en drop immediately, fetch_busy=0, pix_valid=0; no reads issued until the next line_start.
